// File: rtl/store_trace_pkg.sv
// Shared types for the lockstep store-trace checker: checker states, queued store entry, pointer sizing.
package store_trace_pkg;

  localparam int unsigned STC_ADDR_W = 10;
  localparam int unsigned STC_DATA_W = 32;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FAIL  = 2'd1,
    ERROR = 2'd2
  } stc_state_t;

  typedef struct packed {
    logic [STC_ADDR_W-1:0] addr;
    logic [STC_DATA_W-1:0] data;
  } stc_entry_t;

  // Pointer width that stays at least one bit for degenerate depths
  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/store_trace_checker_trace_fifo.sv
// trace_fifo: single-clock FIFO holding captured stores for one core.
// A push into a full FIFO is dropped unless a pop frees the slot in the same cycle.
module trace_fifo
  import store_trace_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned W     = $bits(stc_entry_t)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  push,
  input  logic                  pop,
  input  logic [W-1:0]          din,
  output logic [W-1:0]          head,
  output logic                  full,
  output logic                  empty,
  output logic [ptr_w(DEPTH):0] count
);

  localparam int unsigned PW = ptr_w(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign head  = mem_q[rd_ptr_q];
  assign count = cnt_q;

  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (clr) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: only slots below the count are ever read
  always_ff @(posedge clk) begin
    if (do_push && !clr) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/store_trace_checker.sv
// store_trace_checker: pairs DUT and REF store streams in program order and flags the first divergence.
// Optional watchdog on a lone unmatched head: build with STORE_TRACE_TIMEOUT_EN.
module store_trace_checker
  import store_trace_pkg::*;
#(
  parameter int unsigned ADDR_SIZE = 10,
  parameter int unsigned DATA_SIZE = 32,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned TIMEOUT   = 64
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic                 CLEAR,
  input  logic                 dut_we,
  input  logic [ADDR_SIZE-1:0] dut_addr,
  input  logic [DATA_SIZE-1:0] dut_wdata,
  input  logic                 ref_we,
  input  logic [ADDR_SIZE-1:0] ref_addr,
  input  logic [DATA_SIZE-1:0] ref_wdata,
  output logic [CNT_W-1:0]     match_count,
  output logic                 mismatch,
  output logic                 overflow,
  output logic                 timeout,
  output logic                 idle,
  output logic [ADDR_SIZE-1:0] mis_dut_addr,
  output logic [ADDR_SIZE-1:0] mis_ref_addr,
  output logic [DATA_SIZE-1:0] mis_dut_data,
  output logic [DATA_SIZE-1:0] mis_ref_data
);

  localparam int unsigned EW = ADDR_SIZE + DATA_SIZE;
  localparam int unsigned CW = ptr_w(DEPTH) + 1;

  stc_state_t       state_q, state_d;
  logic             run, pop, dut_push, ref_push, dut_ovf, ref_ovf;
  logic             cmp_hit, mis_hit, to_hit;
  logic [EW-1:0]    dut_head, ref_head;
  logic             dut_full, dut_empty, ref_full, ref_empty;
  logic [CW-1:0]    dut_cnt, ref_cnt;
  logic             cmp_valid_q, cmp_valid_d;
  logic [EW-1:0]    cmp_dut_q, cmp_dut_d, cmp_ref_q, cmp_ref_d;
  logic [EW-1:0]    mis_dut_q, mis_dut_d, mis_ref_q, mis_ref_d;
  logic [CNT_W-1:0] match_count_q, match_count_d;
  logic             mismatch_q, mismatch_d, overflow_q, overflow_d, timeout_q, timeout_d;

  // Cycle events; a failing compare also holds back the pop so queued entries stay intact
  always_comb begin
    run      = (state_q == RUN);
    mis_hit  = run && cmp_valid_q && (cmp_dut_q != cmp_ref_q);
    cmp_hit  = run && cmp_valid_q && (cmp_dut_q == cmp_ref_q);
    pop      = run && !mis_hit && !dut_empty && !ref_empty;
    dut_push = run && dut_we;
    ref_push = run && ref_we;
    dut_ovf  = dut_push && dut_full && !pop;
    ref_ovf  = ref_push && ref_full && !pop;
  end

  trace_fifo #(.DEPTH(DEPTH), .W(EW)) u_dut_fifo (
    .clk(CLK), .rst_n(RESET_N), .clr(CLEAR), .push(dut_push), .pop(pop),
    .din({dut_addr, dut_wdata}), .head(dut_head), .full(dut_full),
    .empty(dut_empty), .count(dut_cnt)
  );

  trace_fifo #(.DEPTH(DEPTH), .W(EW)) u_ref_fifo (
    .clk(CLK), .rst_n(RESET_N), .clr(CLEAR), .push(ref_push), .pop(pop),
    .din({ref_addr, ref_wdata}), .head(ref_head), .full(ref_full),
    .empty(ref_empty), .count(ref_cnt)
  );

`ifdef STORE_TRACE_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] wait_q, wait_d;
  logic            lone;

  // Counts cycles in which exactly one side has an unmatched head
  always_comb begin
    lone   = (dut_cnt == '0) != (ref_cnt == '0);
    wait_d = '0;
    to_hit = 1'b0;
    if (!CLEAR && run && lone) begin
      wait_d = wait_q + TO_W'(1);
      to_hit = (wait_d == TO_W'(TIMEOUT));
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) wait_q <= '0;
    else          wait_q <= wait_d;
  end
`else
  // TIMEOUT only matters when the watchdog is built
  assign to_hit = 1'b0 & (TIMEOUT != 0);
`endif

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state_q <= RUN;
    else          state_q <= state_d;
  end

  // FAIL outranks ERROR when both are raised together
  always_comb begin
    state_d = state_q;
    if (CLEAR)                               state_d = RUN;
    else if (mis_hit)                        state_d = FAIL;
    else if (dut_ovf || ref_ovf || to_hit)   state_d = ERROR;
  end

  always_comb begin
    cmp_valid_d   = pop;
    cmp_dut_d     = pop ? dut_head : cmp_dut_q;
    cmp_ref_d     = pop ? ref_head : cmp_ref_q;
    match_count_d = match_count_q;
    mismatch_d    = mismatch_q | mis_hit;
    overflow_d    = overflow_q | dut_ovf | ref_ovf;
    timeout_d     = timeout_q | to_hit;
    mis_dut_d     = mis_hit ? cmp_dut_q : mis_dut_q;
    mis_ref_d     = mis_hit ? cmp_ref_q : mis_ref_q;
    if (cmp_hit && (match_count_q != '1)) match_count_d = match_count_q + CNT_W'(1);
    if (CLEAR) begin
      cmp_valid_d   = 1'b0;
      cmp_dut_d     = '0;
      cmp_ref_d     = '0;
      match_count_d = '0;
      mismatch_d    = 1'b0;
      overflow_d    = 1'b0;
      timeout_d     = 1'b0;
      mis_dut_d     = '0;
      mis_ref_d     = '0;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cmp_valid_q   <= 1'b0;
      cmp_dut_q     <= '0;
      cmp_ref_q     <= '0;
      match_count_q <= '0;
      mismatch_q    <= 1'b0;
      overflow_q    <= 1'b0;
      timeout_q     <= 1'b0;
      mis_dut_q     <= '0;
      mis_ref_q     <= '0;
    end else begin
      cmp_valid_q   <= cmp_valid_d;
      cmp_dut_q     <= cmp_dut_d;
      cmp_ref_q     <= cmp_ref_d;
      match_count_q <= match_count_d;
      mismatch_q    <= mismatch_d;
      overflow_q    <= overflow_d;
      timeout_q     <= timeout_d;
      mis_dut_q     <= mis_dut_d;
      mis_ref_q     <= mis_ref_d;
    end
  end

  assign match_count  = match_count_q;
  assign mismatch     = mismatch_q;
  assign overflow     = overflow_q;
  assign timeout      = timeout_q;
  assign idle         = run && (dut_cnt == '0) && (ref_cnt == '0);
  assign mis_dut_addr = mis_dut_q[EW-1 -: ADDR_SIZE];
  assign mis_dut_data = mis_dut_q[DATA_SIZE-1:0];
  assign mis_ref_addr = mis_ref_q[EW-1 -: ADDR_SIZE];
  assign mis_ref_data = mis_ref_q[DATA_SIZE-1:0];

endmodule

// File: tb/tb_store_trace_checker.sv
// Bench for store_trace_checker: directed scenarios plus random store streams against a queue-based model.
module tb_store_trace_checker;

  localparam int unsigned AW    = 10;
  localparam int unsigned DW    = 32;
  localparam int unsigned EW    = AW + DW;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned TO    = 16;

  logic          CLK = 1'b0;
  logic          RESET_N, CLEAR, dut_we, ref_we;
  logic [AW-1:0] dut_addr, ref_addr, mis_dut_addr, mis_ref_addr;
  logic [DW-1:0] dut_wdata, ref_wdata, mis_dut_data, mis_ref_data;
  logic [CNT_W-1:0] match_count;
  logic          mismatch, overflow, timeout, idle;

  always #5 CLK = ~CLK;

  store_trace_checker #(
    .ADDR_SIZE(AW), .DATA_SIZE(DW), .DEPTH(DEPTH), .CNT_W(CNT_W), .TIMEOUT(TO)
  ) dut (
    .CLK(CLK), .RESET_N(RESET_N), .CLEAR(CLEAR),
    .dut_we(dut_we), .dut_addr(dut_addr), .dut_wdata(dut_wdata),
    .ref_we(ref_we), .ref_addr(ref_addr), .ref_wdata(ref_wdata),
    .match_count(match_count), .mismatch(mismatch), .overflow(overflow),
    .timeout(timeout), .idle(idle),
    .mis_dut_addr(mis_dut_addr), .mis_ref_addr(mis_ref_addr),
    .mis_dut_data(mis_dut_data), .mis_ref_data(mis_ref_data)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: program-order queues of stores plus the sticky results
  logic [EW-1:0] mq_d[$];
  logic [EW-1:0] mq_r[$];
  bit            m_pv, m_mis, m_ovf, m_to, m_fail, m_err;
  logic [EW-1:0] m_pd, m_pr, m_md, m_mr;
  int            m_cnt, m_wait;

  task automatic model_reset();
    mq_d.delete(); mq_r.delete();
    m_pv = 0; m_mis = 0; m_ovf = 0; m_to = 0; m_fail = 0; m_err = 0;
    m_pd = '0; m_pr = '0; m_md = '0; m_mr = '0; m_cnt = 0; m_wait = 0;
  endtask

  task automatic model_edge(input bit dwe, input logic [EW-1:0] de,
                            input bit rwe, input logic [EW-1:0] re, input bit clr);
    bit run, lone, mis_now, ovf_now, to_now;
    if (clr) begin model_reset(); return; end
    run = !m_fail && !m_err;
    lone = (mq_d.size() == 0) != (mq_r.size() == 0);
    mis_now = 0; ovf_now = 0; to_now = 0;
    if (run && m_pv) begin
      if (m_pd == m_pr) begin
        if (m_cnt < (2**CNT_W) - 1) m_cnt++;
      end else begin
        mis_now = 1; m_md = m_pd; m_mr = m_pr;
      end
    end
    m_pv = run && !mis_now && mq_d.size() > 0 && mq_r.size() > 0;
    if (m_pv) begin m_pd = mq_d.pop_front(); m_pr = mq_r.pop_front(); end
    if (run && dwe) begin
      if (mq_d.size() < DEPTH) mq_d.push_back(de); else ovf_now = 1;
    end
    if (run && rwe) begin
      if (mq_r.size() < DEPTH) mq_r.push_back(re); else ovf_now = 1;
    end
`ifdef STORE_TRACE_TIMEOUT_EN
    if (run && lone) begin m_wait++; if (m_wait == TO) to_now = 1; end
    else m_wait = 0;
`else
    m_wait = lone ? 1 : 0;
`endif
    if (mis_now) m_mis = 1;
    if (ovf_now) m_ovf = 1;
    if (to_now)  m_to  = 1;
    if (mis_now) m_fail = 1;
    else if (ovf_now || to_now) m_err = 1;
  endtask

  function automatic logic [CNT_W+3:0] obs_flags();
    return {match_count, mismatch, overflow, timeout, idle};
  endfunction

  function automatic logic [CNT_W+3:0] exp_flags();
    bit m_idle;
    m_idle = !m_fail && !m_err && mq_d.size() == 0 && mq_r.size() == 0;
    return {CNT_W'(m_cnt), m_mis, m_ovf, m_to, m_idle};
  endfunction

  function automatic logic [2*EW-1:0] obs_mis();
    return {mis_dut_addr, mis_dut_data, mis_ref_addr, mis_ref_data};
  endfunction

  function automatic logic [EW-1:0] ent(input int unsigned a, input int unsigned d);
    return {AW'(a), DW'(d)};
  endfunction

  // One clock: drive, let the edge happen, advance the model, settle
  task automatic tick(input bit dwe, input logic [EW-1:0] de,
                      input bit rwe, input logic [EW-1:0] re, input bit clr);
    dut_we = dwe; {dut_addr, dut_wdata} = de;
    ref_we = rwe; {ref_addr, ref_wdata} = re;
    CLEAR  = clr;
    @(posedge CLK);
    model_edge(dwe, de, rwe, re, clr);
    #1;
    dut_we = 0; ref_we = 0; CLEAR = 0;
  endtask

  task automatic test_reset();
    RESET_N = 0; CLEAR = 0; dut_we = 0; ref_we = 0;
    dut_addr = '0; dut_wdata = '0; ref_addr = '0; ref_wdata = '0;
    model_reset();
    #12;
    total++;
    if (obs_flags() !== {CNT_W'(0), 4'b0001}) begin
      bad++; $display("FAIL reset_flags got=%h exp=%h", obs_flags(), {CNT_W'(0), 4'b0001});
    end
    total++;
    if (obs_mis() !== '0) begin bad++; $display("FAIL reset_mis got=%h exp=0", obs_mis()); end
    @(negedge CLK); RESET_N = 1;
    tick(1, ent(1, 1), 1, ent(1, 1), 0);
    tick(1, ent(2, 2), 0, '0, 0);
    #2 RESET_N = 0;
    #1;
    model_reset();
    total++;
    if (obs_flags() !== {CNT_W'(0), 4'b0001}) begin
      bad++; $display("FAIL async_reset got=%h exp=%h", obs_flags(), {CNT_W'(0), 4'b0001});
    end
    @(negedge CLK); RESET_N = 1;
  endtask

  task automatic test_lockstep();
    for (int i = 0; i < 5; i++) begin
      if (i < 3) tick(1, ent(16 + 4*i, i + 1), 1, ent(16 + 4*i, i + 1), 0);
      else       tick(0, '0, 0, '0, 0);
      total++;
      if (obs_flags() !== exp_flags()) begin
        bad++; $display("FAIL lockstep cyc%0d got=%h exp=%h", i, obs_flags(), exp_flags());
      end
    end
    total++;
    if (match_count !== CNT_W'(3) || mismatch !== 1'b0 || idle !== 1'b1) begin
      bad++; $display("FAIL lockstep_end count=%0d mis=%b idle=%b exp 3/0/1", match_count, mismatch, idle);
    end
  endtask

  task automatic test_skew();
    tick(0, '0, 0, '0, 1);
    for (int i = 0; i < 12; i++) begin
      tick(i < 4, ent(32 + i, 100 + i), (i >= 5) && (i < 9), ent(32 + i - 5, 100 + i - 5), 0);
      total++;
      if (obs_flags() !== exp_flags()) begin
        bad++; $display("FAIL skew cyc%0d got=%h exp=%h", i, obs_flags(), exp_flags());
      end
    end
    total++;
    if (obs_flags() !== {CNT_W'(4), 4'b0001}) begin
      bad++; $display("FAIL skew_end got=%h exp=%h", obs_flags(), {CNT_W'(4), 4'b0001});
    end
  endtask

  task automatic test_mismatch();
    logic [EW-1:0] ds[4];
    logic [EW-1:0] rs[4];
    ds = '{ent(12, 7), ent(16, 5), ent(20, 9), ent(24, 11)};
    rs = '{ent(12, 7), ent(16, 8), ent(20, 9), ent(24, 11)};
    tick(0, '0, 0, '0, 1);
    for (int i = 0; i < 8; i++) begin
      tick(i < 4, (i < 4) ? ds[i] : '0, i < 4, (i < 4) ? rs[i] : '0, 0);
      total++;
      if (obs_flags() !== exp_flags()) begin
        bad++; $display("FAIL mismatch cyc%0d got=%h exp=%h", i, obs_flags(), exp_flags());
      end
    end
    total++;
    if (obs_mis() !== {ent(16, 5), ent(16, 8)} || match_count !== CNT_W'(1) || mismatch !== 1'b1) begin
      bad++; $display("FAIL mismatch_capture got=%h cnt=%0d exp=%h cnt=1", obs_mis(), match_count,
                      {ent(16, 5), ent(16, 8)});
    end
  endtask

  task automatic test_clear();
    tick(0, '0, 0, '0, 1);
    total++;
    if (obs_flags() !== {CNT_W'(0), 4'b0001} || obs_mis() !== '0) begin
      bad++; $display("FAIL clear got=%h mis=%h exp=%h mis=0", obs_flags(), obs_mis(), {CNT_W'(0), 4'b0001});
    end
    tick(1, ent(40, 77), 1, ent(40, 77), 0);
    tick(0, '0, 0, '0, 0);
    tick(0, '0, 0, '0, 0);
    total++;
    if (obs_flags() !== {CNT_W'(1), 4'b0001}) begin
      bad++; $display("FAIL clear_after got=%h exp=%h", obs_flags(), {CNT_W'(1), 4'b0001});
    end
  endtask

  task automatic test_overflow();
    tick(0, '0, 0, '0, 1);
    for (int i = 0; i < 9; i++) begin
      tick(1, ent(i, i * 3), 0, '0, 0);
      total++;
      if (overflow !== (i == 8) || obs_flags() !== exp_flags()) begin
        bad++; $display("FAIL overflow cyc%0d got=%h exp=%h", i, obs_flags(), exp_flags());
      end
    end
    for (int i = 0; i < 3; i++) tick(0, '0, 1, ent(i, i * 3), 0);
    total++;
    if (obs_flags() !== {CNT_W'(0), 4'b0100}) begin
      bad++; $display("FAIL overflow_frozen got=%h exp=%h", obs_flags(), {CNT_W'(0), 4'b0100});
    end
  endtask

  task automatic test_timeout();
    bit want;
    tick(0, '0, 0, '0, 1);
    tick(1, ent(5, 5), 0, '0, 0);
    for (int j = 1; j <= 20; j++) begin
      tick(0, '0, 0, '0, 0);
`ifdef STORE_TRACE_TIMEOUT_EN
      want = (j >= int'(TO));
`else
      want = 1'b0;
`endif
      total++;
      if (timeout !== want || obs_flags() !== exp_flags()) begin
        bad++; $display("FAIL timeout cyc%0d got=%h exp=%h want_to=%b", j, obs_flags(), exp_flags(), want);
      end
    end
  endtask

  task automatic test_random();
    logic [EW-1:0] seq[$];
    int di, ri, bad_at;
    for (int r = 0; r < 8; r++) begin
      tick(0, '0, 0, '0, 1);
      seq.delete();
      for (int k = 0; k < 40; k++) seq.push_back({AW'($urandom), DW'($urandom)});
      bad_at = (r % 2 == 0) ? int'($urandom_range(0, 39)) : -1;
      di = 0; ri = 0;
      for (int c = 0; c < 90; c++) begin
        bit dwe, rwe;
        logic [EW-1:0] re;
        dwe = (di < 40) && ($urandom_range(0, 3) != 0);
        rwe = (ri < 40) && ($urandom_range(0, 3) != 0) && !(r == 3 && c < 30);
        re  = (rwe && ri == bad_at) ? (seq[ri] ^ EW'($urandom_range(1, 255))) : (rwe ? seq[ri] : '0);
        tick(dwe, dwe ? seq[di] : '0, rwe, re, 0);
        if (dwe) di++;
        if (rwe) ri++;
        total++;
        if (obs_flags() !== exp_flags() || obs_mis() !== {m_md, m_mr}) begin
          bad++; $display("FAIL random r%0d c%0d got=%h/%h exp=%h/%h", r, c, obs_flags(), obs_mis(),
                          exp_flags(), {m_md, m_mr});
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_lockstep();
    test_skew();
    test_mismatch();
    test_clear();
    test_overflow();
    test_timeout();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/store_trace_checker.md
Name: store_trace_checker

Overview:
- Lockstep checker that reads the data-memory write streams of two cores and compares them: the pipelined core (DUT) and the single-cycle golden core (REF).
- Each store is captured into a per-side FIFO. Stores are compared pairwise in program order, so pipeline skew between the two cores does not matter.
- Sits beside both cores in the comparison bench. It taps the core→RAM store signals and raises a sticky pass/fail result.

Parameters:
- ADDR_SIZE, 10, data-memory address width.
- DATA_SIZE, 32, store data width.
- DEPTH, 8, entries per FIFO. Power of two, at least 2.
- CNT_W, 16, width of match_count.
- TIMEOUT, 64, maximum cycles an unmatched head may wait. Used only with the optional feature.

Ports:
- CLK  in  1  clock; all state changes on rising edge.
- RESET_N  in  1  asynchronous reset, active low.
- CLEAR  in  1  synchronous clear; same effect as reset.
- dut_we  in  1  DUT store strobe (MemWrite).
- dut_addr  in  ADDR_SIZE  DUT store address.
- dut_wdata  in  DATA_SIZE  DUT store data.
- ref_we  in  1  REF store strobe (d_rw).
- ref_addr  in  ADDR_SIZE  REF store address.
- ref_wdata  in  DATA_SIZE  REF store data.
- match_count  out  CNT_W  number of matched store pairs; saturates at all-ones.
- mismatch  out  1  sticky: a compared pair differed.
- overflow  out  1  sticky: a push was made into a full FIFO.
- timeout  out  1  sticky: watchdog expired. Tied 0 without the optional feature.
- idle  out  1  state RUN and both FIFOs empty.
- mis_dut_addr, mis_ref_addr  out  ADDR_SIZE  captured addresses of the first failing pair.
- mis_dut_data, mis_ref_data  out  DATA_SIZE  captured data of the first failing pair.

Behaviour:
- Reset (RESET_N=0, asynchronous) and CLEAR=1 (at edge):
  - both FIFOs empty, state RUN;
  - all outputs 0 except idle=1.
  - CLEAR has priority over every other event in the same cycle.
- States:
  - RUN: normal operation.
  - FAIL: entered on mismatch.
  - ERROR: entered on overflow or timeout.
  - FAIL and ERROR are absorbing: leaving them requires reset or CLEAR. In these states pushes are ignored, pops stop, and match_count and the captured values freeze.
- Push (RUN only): at the edge with dut_we=1, entry {dut_addr,dut_wdata} is written to the DUT FIFO. The REF side works the same way with ref_we. The two sides are independent.
- Pop/compare (RUN only): if both FIFOs are non-empty at an edge, both heads pop and the pair is registered into a compare stage.
- Compare result appears one cycle after the pop:
  - equal address and data: match_count+1;
  - otherwise: mismatch=1, mis_* load the pair, next state FAIL. Entries already queued are left untouched.
- Full FIFO with a push and a pop in the same cycle: the push is accepted, because the pop frees the slot.
- Full FIFO with a push and no pop: overflow=1, the entry is dropped, next state ERROR.
- Mismatch and overflow in the same cycle: both flags set; state FAIL takes priority.
- Pointers: log2(DEPTH)-bit pointers that wrap modulo DEPTH, plus a count register of log2(DEPTH)+1 bits.
- idle is combinational from the state and the two counts.

Optional Feature:
- Macro: STORE_TRACE_TIMEOUT_EN.
- Defined:
  - a wait counter resets whenever neither FIFO is non-empty alone, i.e. both are empty or both are non-empty;
  - while exactly one FIFO is non-empty in RUN, the counter increments each cycle;
  - when it reaches TIMEOUT: timeout=1, next state ERROR.
- Undefined: no counter is built, timeout is tied 0, and the TIMEOUT parameter has no effect.

Decomposition:
- Package store_trace_pkg holds:
  - enum stc_state_t {RUN, FAIL, ERROR};
  - packed struct stc_entry_t {addr, data}, sized by package constants that default to 10/32;
  - function clog2-safe pointer width.
- Sub-module trace_fifo: synchronous single-clock FIFO with push, pop, full, empty and head; instantiated twice.

Test Plan:
- Reset, then 3 identical stores (addr 0x10/0x14/0x18, data 1/2/3) on both sides in the same cycles → match_count=3 two cycles after the last store; mismatch=0; idle=1.
- REF stores lag DUT by 5 cycles, 4 stores → DUT FIFO reaches 4 entries; match_count=4; no flags.
- Second store differs (addr 0x10, DUT data 0x5, REF data 0x8) → mismatch=1; match_count=1; mis_dut_data=0x5, mis_ref_data=0x8, mis_*_addr=0x10; later stores ignored.
- DEPTH=8, 9 consecutive DUT stores, no REF stores → overflow=1 after the 9th edge, state ERROR; 8 entries retained.
- CLEAR=1 for one cycle while in FAIL → all outputs 0, idle=1; a following matching pair gives match_count=1.
- With STORE_TRACE_TIMEOUT_EN and TIMEOUT=16: 1 DUT store, no REF store → timeout=1 exactly 16 cycles after the push; without the macro, timeout stays 0.
